// File: rtl/instr_decode_ctrl.sv
// Instruction decode/sequence control in front of the register-bank/ALU datapath.
// Each accepted instruction walks IDLE -> DECODE -> EXECUTE and retires on the edge leaving EXECUTE.
module instr_decode_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       inst_in,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [15:0]       wEnable,
  output logic [7:0]        opcode,
  output logic [3:0]        Rdest_select,
  output logic [3:0]        Rsrc_select,
  output logic [15:0]       Imm_in,
  output logic              Imm_select,
  output logic [FLAG_W-1:0] flags_q,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [1:0] {StIdle, StDecode, StExecute} state_e;

  state_e state_q, state_d;

  logic [15:0]       ir_q;
  logic [7:0]        opcode_q;
  logic [3:0]        rdest_q, rsrc_q;
  logic [15:0]       imm_q;
  logic              imm_sel_q;
  logic              wr_q;
  logic              ill_q;
  logic [FLAG_W-1:0] flags_r;
  logic              done_q, illegal_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]  cls;
  logic        is_r, is_ill, is_cmp, is_logic_imm;
  logic [15:0] imm_ext;

  // Decode of the latched instruction word
  always_comb begin
    cls          = ir_q[15:12];
    is_r         = (cls == 4'h0);
    is_ill       = (cls == 4'hF);
    is_cmp       = (is_r && (ir_q[7:4] == 4'hB)) || (cls == 4'hB);
    is_logic_imm = (cls == 4'h1) || (cls == 4'h2) || (cls == 4'h3);
    imm_ext      = is_logic_imm ? {8'h00, ir_q[7:0]} : {{8{ir_q[7]}}, ir_q[7:0]};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (inst_valid) state_d = StDecode;
      StDecode:  state_d = StExecute;
      StExecute: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if ((state_q == StIdle) && inst_valid) begin
      ir_q <= inst_in;
    end
  end

  // Fields an instruction type does not define keep their previous value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q  <= '0;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      imm_q     <= '0;
      imm_sel_q <= 1'b1;
      wr_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else if (state_q == StDecode) begin
      wr_q  <= !is_ill && !is_cmp;
      ill_q <= is_ill;
      if (is_r) begin
        opcode_q  <= {4'h0, ir_q[7:4]};
        rdest_q   <= ir_q[11:8];
        rsrc_q    <= ir_q[3:0];
        imm_sel_q <= 1'b1;
      end else if (!is_ill) begin
        opcode_q  <= {cls, 4'h0};
        rdest_q   <= ir_q[11:8];
        imm_q     <= imm_ext;
        imm_sel_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q    <= (state_q == StExecute);
      illegal_q <= (state_q == StExecute) && ill_q;
      if (state_q == StExecute) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!ill_q) flags_r <= flags_in;
      end
    end
  end

  // Write enable is gated by registered state, so reset removes it asynchronously
  always_comb begin
    inst_ready    = (state_q == StIdle);
    wEnable       = ((state_q == StExecute) && wr_q) ? (16'h0001 << rdest_q) : 16'h0000;
    opcode        = opcode_q;
    Rdest_select  = rdest_q;
    Rsrc_select   = rsrc_q;
    Imm_in        = imm_q;
    Imm_select    = imm_sel_q;
    flags_q       = flags_r;
    done          = done_q;
    illegal       = illegal_q;
    retired_count = cnt_q;
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed and randomized checks of instr_decode_ctrl against a field-level reference model.
// A narrow counter is used so the wrap boundary is reachable quickly.
module tb_instr_decode_ctrl;

  localparam int CNT_W  = 8;
  localparam int FLAG_W = 5;

  logic              clk;
  logic              reset;
  logic [15:0]       inst_in;
  logic              inst_valid;
  logic              inst_ready;
  logic [FLAG_W-1:0] flags_in;
  logic [15:0]       wEnable;
  logic [7:0]        opcode;
  logic [3:0]        Rdest_select;
  logic [3:0]        Rsrc_select;
  logic [15:0]       Imm_in;
  logic              Imm_select;
  logic [FLAG_W-1:0] flags_q;
  logic              done;
  logic              illegal;
  logic [CNT_W-1:0]  retired_count;

  instr_decode_ctrl #(
    .CNT_W (CNT_W),
    .FLAG_W(FLAG_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_in      (inst_in),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .flags_in     (flags_in),
    .wEnable      (wEnable),
    .opcode       (opcode),
    .Rdest_select (Rdest_select),
    .Rsrc_select  (Rsrc_select),
    .Imm_in       (Imm_in),
    .Imm_select   (Imm_select),
    .flags_q      (flags_q),
    .done         (done),
    .illegal      (illegal),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Reference model: architectural view of the visible control fields
  int unsigned m_op, m_rd, m_rs, m_imm, m_sel, m_flags, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_rd = 0; m_rs = 0; m_imm = 0; m_sel = 1; m_flags = 0; m_cnt = 0;
  endtask

  task automatic model_apply(input int unsigned instr, input int unsigned fl,
                             output int unsigned exp_we, output bit ill);
    int unsigned top, mid, b;
    bit wr;
    top = instr / 4096;
    mid = (instr / 16) % 16;
    b   = instr % 256;
    ill = (top == 15);
    wr  = 0;
    if (top == 0) begin
      m_op  = mid;
      m_rd  = (instr / 256) % 16;
      m_rs  = instr % 16;
      m_sel = 1;
      wr    = (mid != 11);
    end else if (!ill) begin
      m_op  = top * 16;
      m_rd  = (instr / 256) % 16;
      m_sel = 0;
      m_imm = (top <= 3 || b < 128) ? b : b + 'hFF00;
      wr    = (top != 11);
    end
    exp_we = wr ? (1 << m_rd) : 0;
    if (!ill) m_flags = fl;
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, inst_ready, 1);
    check({tag, "_we"}, wEnable, 0);
    check({tag, "_op"}, opcode, 0);
    check({tag, "_rd"}, Rdest_select, 0);
    check({tag, "_rs"}, Rsrc_select, 0);
    check({tag, "_imm"}, Imm_in, 0);
    check({tag, "_sel"}, Imm_select, 1);
    check({tag, "_flags"}, flags_q, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ill"}, illegal, 0);
    check({tag, "_cnt"}, retired_count, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after retirement
  task automatic run_instr(input logic [15:0] instr, input logic [FLAG_W-1:0] fl);
    int unsigned exp_we;
    bit ill;
    model_apply(instr, fl, exp_we, ill);
    check("ready_idle", inst_ready, 1);
    inst_in    = instr;
    inst_valid = 1'b1;
    flags_in   = fl;
    @(posedge clk); @(negedge clk);
    check("ready_dec", inst_ready, 0);
    check("we_dec", wEnable, 0);
    check("done_dec", done, 0);
    inst_valid = 1'($urandom_range(0, 1));
    inst_in    = 16'($urandom);
    @(posedge clk); @(negedge clk);
    check("ready_exe", inst_ready, 0);
    check("op_exe", opcode, m_op);
    check("rd_exe", Rdest_select, m_rd);
    check("rs_exe", Rsrc_select, m_rs);
    check("imm_exe", Imm_in, m_imm);
    check("sel_exe", Imm_select, m_sel);
    check("we_exe", wEnable, exp_we);
    inst_valid = 1'($urandom_range(0, 1));
    @(posedge clk); @(negedge clk);
    inst_valid = 1'b0;
    check("done_ret", done, 1);
    check("ill_ret", illegal, 32'(ill));
    check("flags_ret", flags_q, m_flags);
    check("cnt_ret", retired_count, m_cnt);
    check("we_ret", wEnable, 0);
    check("ready_ret", inst_ready, 1);
  endtask

  initial begin
    int accepts;
    reset      = 1'b1;
    inst_valid = 1'b0;
    inst_in    = '0;
    flags_in   = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    run_instr(16'h0354, 5'b00011);
    run_instr(16'h5AF0, 5'b01000);
    run_instr(16'h12F0, 5'b00110);
    run_instr(16'h01B2, 5'b10101);
    run_instr(16'hF123, 5'b01010);
    run_instr(16'hB07F, 5'b11111);

    // Reset asserted in the middle of EXECUTE
    inst_in    = 16'h0354;
    inst_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    inst_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_we_before", wEnable, 16'h0008);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_vals("mid");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_no_done", done, 0);
    check("mid_cnt", retired_count, 0);

    for (int i = 0; i < 40; i++) begin
      run_instr(16'($urandom), 5'($urandom));
    end

    // Back-to-back: valid held high, one accept every third cycle
    accepts    = 0;
    inst_in    = 16'h5AF0;
    flags_in   = 5'b00000;
    inst_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (inst_ready) accepts++;
      check("b2b_onehot", 32'($countones(wEnable) <= 1), 1);
      if (!inst_ready && i % 3 == 0) check("b2b_ready", inst_ready, 1);
      @(negedge clk);
    end
    inst_valid = 1'b0;
    check("b2b_accepts", accepts, 10);
    for (int i = 0; i < 10; i++) begin
      int unsigned we;
      bit il;
      model_apply(16'h5AF0, 0, we, il);
    end
    check("b2b_cnt", retired_count, m_cnt);
    check("b2b_done", done, 1);
    check("b2b_imm", Imm_in, m_imm);

    // Counter wrap at all-ones
    while (m_cnt != (1 << CNT_W) - 1) begin
      run_instr(16'h0354, 5'($urandom));
    end
    check("cnt_pre_wrap", retired_count, (1 << CNT_W) - 1);
    run_instr(16'h12F0, 5'b00001);
    check("cnt_wrap", retired_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Control stage directly upstream of the register-bank/ALU datapath.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it into datapath controls: one-hot write enable, ALU opcode, Rdest/Rsrc selects, immediate value and immediate select.
- Sequences each instruction through a 3-state FSM, captures the ALU flags, and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- FLAG_W, 5, width of ALU flag vector.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_in  in  16  instruction word.
- inst_valid  in  1  inst_in valid.
- inst_ready  out  1  block can accept an instruction.
- flags_in  in  FLAG_W  flags from the ALU.
- wEnable  out  16  one-hot register write enable.
- opcode  out  8  ALU opcode.
- Rdest_select  out  4  Rdest mux select.
- Rsrc_select  out  4  Rsrc mux select.
- Imm_in  out  16  extended immediate.
- Imm_select  out  1  0 = immediate operand, 1 = Rsrc operand.
- flags_q  out  FLAG_W  flags latched at the last retired instruction.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse when an illegal instruction retires.
- retired_count  out  CNT_W  count of retired instructions, legal and illegal.

Behaviour:
- Clock and reset:
  - Single clock.
  - reset is asynchronous and active-high.
  - All outputs are registered or derived from registered state.
- Reset values:
  - State = IDLE, inst_ready = 1.
  - wEnable = 0, opcode = 0, Rdest_select = 0, Rsrc_select = 0, Imm_in = 0, Imm_select = 1.
  - flags_q = 0, done = 0, illegal = 0, retired_count = 0.
- Decode of the latched instruction IR:
  - R-type when IR[15:12] = 0000:
    - opcode = {0000, IR[7:4]}, Rdest_select = IR[11:8], Rsrc_select = IR[3:0], Imm_select = 1.
    - Imm_in holds its previous value.
  - I-type when IR[15:12] is in 0001..1110:
    - opcode = {IR[15:12], 0000}, Rdest_select = IR[11:8], Imm_select = 0.
    - Rsrc_select holds its previous value.
    - Imm_in = zero-extend(IR[7:0]) for IR[15:12] in {0001 ANDI, 0010 ORI, 0011 XORI}; sign-extend(IR[7:0]) for all other I-type codes.
  - IR[15:12] = 1111 is illegal.
  - Compare (no writeback): R-type with IR[7:4] = 1011, or I-type with IR[15:12] = 1011.
- FSM:
  - IDLE:
    - inst_ready = 1.
    - On inst_valid & inst_ready at a rising edge: IR <= inst_in, go to DECODE.
    - Datapath controls hold their last values; wEnable = 0.
  - DECODE (1 cycle):
    - inst_ready = 0, wEnable = 0.
    - Decoded controls are registered, so they are stable from the start of EXECUTE.
    - Next state: EXECUTE.
  - EXECUTE (1 cycle):
    - inst_ready = 0; controls held.
    - wEnable = one-hot(Rdest_select) unless the instruction is a compare or illegal, in which case wEnable = 0.
    - At the edge leaving EXECUTE:
      - flags_q <= flags_in, except an illegal instruction leaves flags_q unchanged.
      - done pulses for the following cycle; illegal also pulses if the instruction is illegal.
      - retired_count increments, wrapping from all-ones to 0.
    - Next state: IDLE.
- Latency:
  - Handshake accepted at edge k → controls valid after edge k+1 → register written at edge k+2 → done high and inst_ready = 1 in the cycle after edge k+2.
  - Throughput: 1 instruction per 3 cycles.
- Handshake rules:
  - inst_in is sampled only on inst_valid & inst_ready.
  - inst_valid while not ready is ignored; the source must hold the instruction.
  - No accept can occur in the same cycle as EXECUTE.
- wEnable is never multi-hot and never nonzero outside EXECUTE.
- Reset mid-operation:
  - Any state returns to IDLE immediately.
  - wEnable drops to 0 asynchronously; no partial write occurs.
  - A pending done/illegal pulse is cancelled.

Test Plan:
- Reset asserted mid-EXECUTE of ADD R3,R4 (0x0354) → wEnable = 0 immediately; all outputs at reset values; inst_ready = 1; retired_count = 0.
- inst_in = 0x0354 (ADD R3,R4), one valid pulse → DECODE then EXECUTE: opcode = 0x05, Rdest_select = 3, Rsrc_select = 4, Imm_select = 1; wEnable = 0x0008 for exactly one cycle; done pulses; retired_count = 1.
- inst_in = 0x5AF0 (ADDI R10, -16) → opcode = 0x50, Imm_in = 0xFFF0, Imm_select = 0, wEnable = 0x0400.
- inst_in = 0x12F0 (ANDI R2, 0xF0) → Imm_in = 0x00F0 (zero-extended), wEnable = 0x0004.
- inst_in = 0x01B2 (CMP R1,R2) with flags_in = 5'b10101 → wEnable stays 0 throughout; flags_q = 5'b10101 after retire.
- inst_in = 0xF123 → wEnable stays 0; illegal and done pulse together; flags_q unchanged.
- inst_valid held high with back-to-back instructions → exactly one accept per 3 cycles; no accept while inst_ready = 0.
- retired_count preset by 0xFFFF retirements → next retire wraps to 0x0000.
